// File: rtl/filter_spad_ctrl_if.sv
// Bundle of config, load stream, weight stream and spad pins for the filter spad sequencer.
// The controller connects through the master modport; its environment uses slave.
interface filter_spad_ctrl_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 8
);
  logic              cfg_start;
  logic [ADDR_W-1:0] cfg_len;
  logic [ADDR_W-1:0] cfg_passes;
  logic              cfg_skip_load;
  logic              ld_valid;
  logic [DATA_W-1:0] ld_data;
  logic              ld_ready;
  logic              w_valid;
  logic [DATA_W-1:0] w_data;
  logic              w_ready;
  logic [ADDR_W-1:0] spad_addr;
  logic              spad_we;
  logic [DATA_W-1:0] spad_din;
  logic [DATA_W-1:0] spad_dout;
  logic              busy;
  logic              done;

  modport master (
    input  cfg_start, cfg_len, cfg_passes, cfg_skip_load, ld_valid, ld_data, w_ready, spad_dout,
    output ld_ready, w_valid, w_data, spad_addr, spad_we, spad_din, busy, done
  );

  modport slave (
    output cfg_start, cfg_len, cfg_passes, cfg_skip_load, ld_valid, ld_data, w_ready, spad_dout,
    input  ld_ready, w_valid, w_data, spad_addr, spad_we, spad_din, busy, done
  );
endinterface

// File: rtl/filter_spad_ctrl.sv
// Filter scratch-pad sequencer: loads a run of weights into the negedge spad, then replays
// the run to the MAC for a configurable number of passes at one word per cycle.
module filter_spad_ctrl #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 224
) (
  input logic                clk,
  input logic                rst_n,
  filter_spad_ctrl_if.master bus
);
  typedef enum logic [1:0] {StIdle, StLoad, StRead, StDone} state_e;

  localparam logic [ADDR_W-1:0] DepthA = ADDR_W'(DEPTH);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [ADDR_W-1:0] passes_q, passes_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0] pass_q, pass_d;
  logic              w_valid_q, w_valid_d;
  logic [ADDR_W-1:0] start_len, len_last;
  logic              ld_hs, w_hs;

  assign start_len     = (bus.cfg_len > DepthA) ? DepthA : bus.cfg_len;
  assign len_last      = len_q - 1'b1;
  // The spad output is already aligned with rd_ptr by the negedge read, so no extra stage.
  assign bus.w_data    = DATA_W'(bus.spad_dout);
  assign bus.spad_din  = DATA_W'(bus.ld_data);
  assign bus.w_valid   = w_valid_q;
  assign bus.busy      = (state_q != StIdle);

  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    passes_d      = passes_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    pass_d        = pass_q;
    w_valid_d     = w_valid_q;
    ld_hs         = 1'b0;
    w_hs          = 1'b0;
    bus.ld_ready  = 1'b0;
    bus.spad_we   = 1'b0;
    bus.spad_addr = '0;
    bus.done      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.cfg_start) begin
          len_d     = start_len;
          passes_d  = bus.cfg_passes;
          wr_ptr_d  = '0;
          rd_ptr_d  = '0;
          pass_d    = '0;
          w_valid_d = 1'b0;
          if (start_len == '0) begin
            state_d = StDone;
          end else if (bus.cfg_skip_load) begin
            state_d = (bus.cfg_passes == '0) ? StDone : StRead;
          end else begin
            state_d = StLoad;
          end
        end
      end
      StLoad: begin
        bus.ld_ready  = (wr_ptr_q < len_q);
        ld_hs         = bus.ld_valid & bus.ld_ready;
        // Gate with reset so an aborting cycle never commits a write on its negedge.
        bus.spad_we   = ld_hs & rst_n;
        bus.spad_addr = wr_ptr_q;
        if (ld_hs) begin
          if (wr_ptr_q == len_last) begin
            rd_ptr_d  = '0;
            pass_d    = '0;
            w_valid_d = 1'b0;
            state_d   = (passes_q == '0) ? StDone : StRead;
          end else begin
            wr_ptr_d = wr_ptr_q + 1'b1;
          end
        end
      end
      StRead: begin
        bus.spad_addr = rd_ptr_q;
        w_hs          = w_valid_q & bus.w_ready;
        w_valid_d     = 1'b1;
        if (w_hs) begin
          if (rd_ptr_q == len_last) begin
            rd_ptr_d = '0;
            if (pass_q == passes_q - 1'b1) begin
              pass_d    = '0;
              w_valid_d = 1'b0;
              state_d   = StDone;
            end else begin
              pass_d = pass_q + 1'b1;
            end
          end else begin
            rd_ptr_d = rd_ptr_q + 1'b1;
          end
        end
      end
      StDone: begin
        bus.done = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      len_q     <= '0;
      passes_q  <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      pass_q    <= '0;
      w_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      passes_q  <= passes_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      pass_q    <= pass_d;
      w_valid_q <= w_valid_d;
    end
  end
endmodule

// File: tb/tb_filter_spad_ctrl.sv
// Bench for filter_spad_ctrl: a negedge spad model, a run driver that queues expected spad
// writes and replayed words, and a monitor that checks every write and every presented word.
module tb_filter_spad_ctrl;
  typedef struct {
    logic [7:0]  addr;
    logic [15:0] data;
  } acc_t;

  localparam bit [6:0] VPat = 7'b1001101;

  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  acc_t        wr_q[$];
  acc_t        rd_q[$];
  acc_t        mon_e;
  logic [15:0] spad_mem[256];
  logic [15:0] model_mem[256];
  logic [15:0] ld_words[256];

  filter_spad_ctrl_if #(.DATA_W(16), .ADDR_W(8)) bus ();

  filter_spad_ctrl #(.DATA_W(16), .ADDR_W(8), .DEPTH(224)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Negedge-sampled spad, read-before-write.
  always @(negedge clk) begin
    if (bus.spad_we) spad_mem[bus.spad_addr] <= bus.spad_din;
    bus.spad_dout <= spad_mem[bus.spad_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: sampled late in the cycle, after the spad has produced its output.
  always @(negedge clk) begin
    #2;
    if (bus.spad_we) begin
      if (wr_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_write: actual addr=%0d data=%h required no write (cycle %0d)",
                 bus.spad_addr, bus.spad_din, cyc);
      end else begin
        mon_e = wr_q.pop_front();
        chk("write_addr", 32'(bus.spad_addr), 32'(mon_e.addr));
        chk("write_data", 32'(bus.spad_din), 32'(mon_e.data));
      end
    end
    if (bus.w_valid) begin
      if (rd_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_w_valid: actual w_data=%h required w_valid=0 (cycle %0d)",
                 bus.w_data, cyc);
      end else begin
        mon_e = rd_q[0];
        chk("read_addr", 32'(bus.spad_addr), 32'(mon_e.addr));
        chk("read_data", 32'(bus.w_data), 32'(mon_e.data));
        if (bus.w_ready) void'(rd_q.pop_front());
      end
    end
  end

  // One complete run: model expectations, start pulse, then drive until done (or reset).
  task automatic run(input int len, input int passes, input bit skip, input int vmode,
                     input int wmode, input bit chk_lat, input int rst_at);
    int   l_eff, lat, idx, rd_hs, stall, start_cyc;
    bit   fin, rst_hit;
    acc_t e;
    l_eff = (len > 224) ? 224 : len;
    if (l_eff > 0 && !skip) begin
      for (int i = 0; i < l_eff; i++) begin
        model_mem[i] = ld_words[i];
        e.addr = 8'(i);
        e.data = ld_words[i];
        wr_q.push_back(e);
      end
    end
    if (l_eff > 0 && passes > 0) begin
      for (int p = 0; p < passes; p++) begin
        for (int i = 0; i < l_eff; i++) begin
          e.addr = 8'(i);
          e.data = model_mem[i];
          rd_q.push_back(e);
        end
      end
    end
    lat = (l_eff == 0) ? 1 : ((skip ? 0 : l_eff) + (passes > 0 ? 1 + l_eff * passes : 0) + 1);

    @(posedge clk); #1;
    bus.cfg_start     = 1'b1;
    bus.cfg_len       = 8'(len);
    bus.cfg_passes    = 8'(passes);
    bus.cfg_skip_load = skip;
    bus.ld_valid      = 1'b0;
    bus.w_ready       = 1'b0;
    @(negedge clk); #2;
    start_cyc = cyc;
    idx = 0; rd_hs = 0; stall = 0; fin = 1'b0; rst_hit = 1'b0;

    for (int k = 0; k < 3000 && !fin; k++) begin
      @(posedge clk); #1;
      bus.cfg_start     = 1'b0;
      bus.cfg_len       = 8'($urandom);
      bus.cfg_passes    = 8'($urandom);
      bus.cfg_skip_load = 1'($urandom);
      case (vmode)
        0:       bus.ld_valid = 1'b1;
        1:       bus.ld_valid = 1'($urandom);
        default: bus.ld_valid = VPat[6 - (k % 7)];
      endcase
      bus.ld_data = (idx < 256) ? ld_words[idx] : 16'($urandom);
      case (wmode)
        0:       bus.w_ready = 1'b1;
        1:       bus.w_ready = 1'($urandom);
        default: begin
          if (rd_hs == 1 && bus.w_valid && stall < 3) begin
            bus.w_ready = 1'b0;
            stall++;
          end else begin
            bus.w_ready = 1'b1;
          end
        end
      endcase
      if (rst_at >= 0 && rd_hs == rst_at && bus.w_valid) begin
        rst_n       = 1'b0;
        bus.w_ready = 1'b0;
        rst_hit     = 1'b1;
      end
      @(negedge clk); #2;
      if (bus.ld_valid && bus.ld_ready) idx++;
      if (bus.w_valid && bus.w_ready) rd_hs++;
      if (bus.done || rst_hit) fin = 1'b1;
    end

    if (!fin) begin
      vectors++;
      miscompares++;
      $display("FAIL run_timeout: actual no done after 3000 cycles, required done (len=%0d)", len);
    end else if (rst_hit) begin
      @(posedge clk); #1;
      rst_n        = 1'b1;
      bus.w_ready  = 1'b0;
      bus.ld_valid = 1'b0;
      @(negedge clk); #2;
      chk("reset_w_valid", 32'(bus.w_valid), 32'd0);
      chk("reset_busy", 32'(bus.busy), 32'd0);
      chk("reset_no_done", 32'(bus.done), 32'd0);
      rd_q.delete();
      wr_q.delete();
    end else begin
      if (chk_lat) chk("start_to_done_cycles", 32'(cyc - start_cyc), 32'(lat));
      @(posedge clk); #1;
      bus.ld_valid = 1'b0;
      bus.w_ready  = 1'b0;
      @(negedge clk); #2;
      chk("busy_after_done", 32'(bus.busy), 32'd0);
      chk("done_one_cycle", 32'(bus.done), 32'd0);
      chk("writes_drained", 32'(wr_q.size()), 32'd0);
      chk("reads_drained", 32'(rd_q.size()), 32'd0);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      spad_mem[i]  = 16'h0;
      model_mem[i] = 16'h0;
      ld_words[i]  = 16'h0;
    end
    rst_n             = 1'b0;
    bus.cfg_start     = 1'b0;
    bus.cfg_len       = '0;
    bus.cfg_passes    = '0;
    bus.cfg_skip_load = 1'b0;
    bus.ld_valid      = 1'b1;
    bus.ld_data       = '0;
    bus.w_ready       = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); #2;
    chk("reset_busy_init", 32'(bus.busy), 32'd0);
    chk("reset_w_valid_init", 32'(bus.w_valid), 32'd0);
    chk("reset_done_init", 32'(bus.done), 32'd0);
    chk("reset_ld_ready_init", 32'(bus.ld_ready), 32'd0);
    chk("reset_spad_we_init", 32'(bus.spad_we), 32'd0);
    @(posedge clk); #1;
    rst_n        = 1'b1;
    bus.ld_valid = 1'b0;
    bus.w_ready  = 1'b0;

    ld_words[0] = 16'h0011; ld_words[1] = 16'h0022;
    ld_words[2] = 16'h0033; ld_words[3] = 16'h0044;
    run(4, 2, 1'b0, 0, 0, 1'b1, -1);   // load/replay, 4+1+8+1 cycles
    run(4, 2, 1'b0, 0, 2, 1'b0, -1);   // 3-cycle stall on the 2nd word
    run(4, 2, 1'b0, 2, 0, 1'b0, -1);   // upstream gaps
    run(3, 1, 1'b1, 0, 0, 1'b1, -1);   // skip-load replay of 0x11, 0x22, 0x33

    for (int i = 0; i < 256; i++) ld_words[i] = 16'($urandom);
    run(250, 1, 1'b0, 0, 0, 1'b1, -1); // clamped to 224 words
    run(0, 2, 1'b0, 0, 0, 1'b1, -1);   // empty run
    for (int i = 0; i < 8; i++) ld_words[i] = 16'($urandom);
    run(5, 0, 1'b0, 0, 0, 1'b1, -1);   // load only, no replay
    run(4, 2, 1'b1, 0, 0, 1'b0, 2);    // reset during the 3rd word
    run(4, 1, 1'b1, 0, 0, 1'b1, -1);   // replay from addr 0 after reset

    for (int r = 0; r < 20; r++) begin
      int ln, ps, vm, wm;
      bit sk;
      ln = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 12));
      ps = int'($urandom_range(0, 3));
      sk = 1'($urandom);
      vm = int'($urandom_range(0, 1));
      wm = int'($urandom_range(0, 1));
      for (int i = 0; i < ln; i++) ld_words[i] = 16'($urandom);
      run(ln, ps, sk, vm, wm, (vm == 0 && wm == 0), -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/filter_spad_ctrl.md
# filter_spad_ctrl

Sequencer for the PE filter scratch pad (224 x 16-bit, negative-edge SRAM). It loads a run of filter weights from an upstream valid/ready stream into the spad, then replays them to the MAC datapath over a configurable number of passes, with a valid/ready handshake and full throughput. The block sits between the PE's filter input port and the multiplier operand mux, and it is the only master of the spad's addr/we/data_in pins.

## Interface
- DATA_W, 16, weight width (matches the spad word)
- ADDR_W, 8, spad address width
- DEPTH, 224, spad capacity in words

- clk  input  1  system clock; all controller state updates on posedge, spad samples on negedge
- rst_n  input  1  synchronous, active-low reset
- cfg_start  input  1  one-cycle start pulse; honoured only in IDLE
- cfg_len  input  ADDR_W  number of weights per filter run; sampled at start
- cfg_passes  input  ADDR_W  number of replay passes; sampled at start
- cfg_skip_load  input  1  1: reuse current spad contents, go straight to READ
- ld_valid  input  1  upstream weight valid
- ld_data  input  DATA_W  upstream weight
- ld_ready  output  1  controller accepts weight this cycle
- w_valid  output  1  w_data holds a valid weight
- w_data  output  DATA_W  weight to MAC, driven directly from spad_dout
- w_ready  input  1  MAC consumes w_data this cycle
- spad_addr  output  ADDR_W  to spad addr
- spad_we  output  1  to spad we
- spad_din  output  DATA_W  to spad data_in
- spad_dout  input  DATA_W  from spad data_out
- busy  output  1  high in any state except IDLE
- done  output  1  one-cycle pulse at end of run

## Operation
- States: IDLE, LOAD, READ, DONE.
- IDLE: on cfg_start, latch len = min(cfg_len, DEPTH) and passes = cfg_passes.
  - len == 0 -> DONE.
  - cfg_skip_load -> READ (passes == 0 -> DONE).
  - Otherwise -> LOAD with wr_ptr = 0.
- LOAD:
  - ld_ready = 1 while wr_ptr < len.
  - spad_we = ld_valid & ld_ready, spad_addr = wr_ptr, spad_din = ld_data. All three are combinational, so the write lands on the negedge of the handshake cycle.
  - Each handshake increments wr_ptr.
  - The handshake with wr_ptr == len-1 -> READ with rd_ptr = 0 and pass = 0, or -> DONE if passes == 0.
- READ:
  - spad_we = 0 and spad_addr = rd_ptr.
  - w_valid is a register: 0 on the first READ cycle (fill), 1 afterwards until exit.
  - On a handshake (w_valid & w_ready):
    - rd_ptr == len-1: rd_ptr wraps to 0 and pass increments.
    - rd_ptr == len-1 and pass == passes-1: -> DONE and w_valid is cleared.
    - Otherwise rd_ptr increments.
  - Stall (w_valid & ~w_ready): rd_ptr holds, so spad_addr and spad_dout stay stable.
- DONE: done = 1 for one cycle, then -> IDLE.
- Outputs outside their owning state:
  - ld_ready = 0, spad_we = 0, w_valid = 0.
  - spad_addr = 0 in IDLE and DONE.
- Width rules: wr_ptr, rd_ptr and pass are ADDR_W bits. cfg_len > DEPTH is clamped to DEPTH. No pointer ever exceeds len-1.
- cfg_start outside IDLE is ignored. Config inputs are don't-care except in the start cycle.

## Timing
- Reset (rst_n = 0 at a posedge): state = IDLE, all pointers 0, w_valid = 0, done = 0, busy = 0.
  - spad_we is forced 0 combinationally while rst_n = 0, so no spurious write occurs on that cycle's negedge.
  - Spad contents are not cleared.
- Reset mid-LOAD or mid-READ: abort with no done pulse. Partially written spad contents remain.
- Start -> first ld_ready: 1 cycle (the state register update).
- Load throughput: 1 word/cycle.
- Read latency:
  - The address is presented after posedge k and sampled by the spad at negedge k+0.5.
  - spad_dout is valid at posedge k+1.
  - First w_valid therefore appears 1 cycle after entering READ; after that, throughput is 1 word/cycle with no inter-pass bubble.
- Last READ handshake at posedge k: done is high in cycle k+1, busy drops in cycle k+2.
- LOAD -> READ: READ is entered in the cycle after the last write handshake. The spad write completes at that handshake cycle's negedge, before the first read negedge, so there is no read-after-write hazard.

## Test plan
- Load/replay:
  - Stimulus: cfg_len = 4, cfg_passes = 2, ld_data = 0x11, 0x22, 0x33, 0x44 with ld_valid held high.
  - Required: 4 writes to addrs 0..3; w_data sequence 0x11, 0x22, 0x33, 0x44, 0x11, 0x22, 0x33, 0x44 on consecutive cycles with w_ready = 1; one done pulse; total of 4 + 1 + 8 + 1 cycles from start.
- Backpressure:
  - Stimulus: the same run with w_ready low for 3 cycles on the 2nd word.
  - Required: w_data = 0x22 and spad_addr = 1 held stable for all 3 cycles; no word dropped or duplicated.
- Upstream gaps:
  - Stimulus: ld_valid toggling 1,0,0,1,1,0,1.
  - Required: spad_we high only on handshake cycles; wr_ptr advances only then; READ is entered only after the 4th write.
- Skip-load and clamp:
  - Stimulus 1: cfg_skip_load = 1, cfg_len = 3, cfg_passes = 1 after the first test.
  - Required 1: no spad_we; output 0x11, 0x22, 0x33.
  - Stimulus 2: cfg_len = 250.
  - Required 2: ld_ready drops after 224 writes (addr 223 is the last).
- Degenerate config:
  - Stimulus 1: cfg_len = 0.
  - Required 1: done 1 cycle after start; no ld_ready, no w_valid.
  - Stimulus 2: cfg_passes = 0 without skip-load.
  - Required 2: load completes, then done with no w_valid.
- Reset mid-READ:
  - Stimulus: assert rst_n = 0 during the 3rd word.
  - Required: at the next posedge w_valid = 0, busy = 0, no done pulse; a fresh cfg_start with cfg_skip_load = 1 replays from addr 0.
